// File: rtl/core_msg_collector_if.sv
// Message-in / stream-out bundle for the core message collector.
// The slave view belongs to the collector; the master view to whatever surrounds it.
interface core_msg_collector_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] core_msg_data;
  logic                  core_msg_valid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    output core_msg_data, core_msg_valid, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    input  core_msg_data, core_msg_valid, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/core_msg_collector.sv
// Buffers unstallable core messages into a first-word-fall-through stream.
// Storage is a (DEPTH-1)-entry array behind one output register; overruns are counted, not stalled.
module core_msg_collector #(
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  core_msg_collector_if.slave         msg,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count,
  output logic                        overflow,
  input  logic                        clear_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ARR_N = DEPTH - 1;

  logic [DATA_WIDTH-1:0] mem [0:ARR_N-1];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      occ_q;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  rst_ok;

  logic                  push, pop, accept, drop;
  logic                  out_load, bypass, arr_wr, arr_rd, arr_empty;
  logic [OCC_W-1:0]      arr_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(ARR_N - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + DROP_CNT_WIDTH'(1);
  endfunction

  assign occupancy         = occ_q;
  assign msg.m_axis_tdata  = data_p1;
  assign msg.m_axis_tvalid = vld_p1;

  // Accept/route decisions; the array only holds words while the output register is full.
  always_comb begin
    push      = msg.core_msg_valid & rst_ok;
    pop       = vld_p1 & msg.m_axis_tready;
    arr_cnt   = occ_q - OCC_W'(vld_p1);
    arr_empty = (arr_cnt == '0);
    accept    = push & ((occ_q < OCC_W'(DEPTH)) | pop);
    drop      = push & ~accept;
    out_load  = ~vld_p1 | pop;
    bypass    = accept & arr_empty & out_load;
    arr_wr    = accept & ~bypass;
    arr_rd    = out_load & ~arr_empty;
  end

  // Holds off pushes for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ok <= 1'b0;
    else        rst_ok <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (arr_wr) mem[wr_ptr] <= msg.core_msg_data;
  end

  // Output stage p1: refills from the array first, else straight from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ_q   <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (arr_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (arr_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (out_load) begin
        vld_p1 <= arr_rd | bypass;
        if (arr_rd)      data_p1 <= mem[rd_ptr];
        else if (bypass) data_p1 <= msg.core_msg_data;
      end
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // A drop in the clearing cycle survives the clear as a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      drop_count <= clear_stats ? DROP_CNT_WIDTH'(1) : sat_inc(drop_count);
      overflow   <= 1'b1;
    end else if (clear_stats) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_msg_collector.sv
// Directed bench for core_msg_collector (DEPTH 16, 64-bit data, 4-bit drop counter).
module tb_core_msg_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_stats = 1'b0;
  logic [4:0] occupancy;
  logic [3:0] drop_count;
  logic       overflow;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] q[$];
  int          mdrop;
  logic        push_r, rdy_r, pop_m, acc_m;
  logic [63:0] d_r;

  core_msg_collector_if #(.DATA_WIDTH(64)) bus ();

  core_msg_collector #(
    .DATA_WIDTH(64), .DEPTH(16), .DROP_CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .msg(bus), .occupancy(occupancy),
    .drop_count(drop_count), .overflow(overflow), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    bus.core_msg_valid = v;
    bus.core_msg_data  = d;
    bus.m_axis_tready  = r;
  endtask

  initial begin
    drive(1'b0, 64'h0, 1'b0);
    #2;
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
    check("rst_tdata", bus.m_axis_tdata, 64'h0);
    check("rst_occ", 64'(occupancy), 64'h0);
    check("rst_drop", 64'(drop_count), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);

    // Release mid-cycle; a push in the first cycle after release is ignored.
    tick(); tick();
    rst_n = 1'b1;
    drive(1'b1, 64'hDEAD, 1'b0);
    tick();
    check("post_rst_ignore_occ", 64'(occupancy), 64'h0);
    check("post_rst_ignore_vld", 64'(bus.m_axis_tvalid), 64'h0);

    // Single message, latency 1.
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    tick();
    check("single_vld", 64'(bus.m_axis_tvalid), 64'h1);
    check("single_data", bus.m_axis_tdata, 64'h0123_4567_89AB_CDEF);
    check("single_occ1", 64'(occupancy), 64'h1);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check("single_vld0", 64'(bus.m_axis_tvalid), 64'h0);
    check("single_occ0", 64'(occupancy), 64'h0);

    // Fill with 1..20 while stalled: 16 kept, 4 dropped.
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 64'(i), 1'b0);
      tick();
    end
    drive(1'b0, 64'h0, 1'b0);
    check("fill_occ", 64'(occupancy), 64'd16);
    check("fill_drop", 64'(drop_count), 64'd4);
    check("fill_ovf", 64'(overflow), 64'h1);
    tick();
    check("stall_hold_data", bus.m_axis_tdata, 64'd1);
    check("stall_hold_vld", 64'(bus.m_axis_tvalid), 64'h1);
    bus.m_axis_tready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("drain_vld", 64'(bus.m_axis_tvalid), 64'h1);
      check("drain_data", bus.m_axis_tdata, 64'(k));
      check("drain_occ", 64'(occupancy), 64'(17 - k));
      tick();
    end
    check("drain_empty_vld", 64'(bus.m_axis_tvalid), 64'h0);
    check("drain_empty_occ", 64'(occupancy), 64'h0);

    // Plain clear.
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clr_drop", 64'(drop_count), 64'h0);
    check("clr_ovf", 64'(overflow), 64'h0);

    // Full plus simultaneous pop.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 64'h100 + 64'(i), 1'b0);
      tick();
    end
    check("full_occ", 64'(occupancy), 64'd16);
    drive(1'b1, 64'hAA, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b1);
    check("fullpop_occ", 64'(occupancy), 64'd16);
    check("fullpop_drop", 64'(drop_count), 64'h0);
    for (int k = 2; k <= 16; k++) begin
      check("fullpop_data", bus.m_axis_tdata, 64'h100 + 64'(k));
      tick();
    end
    check("fullpop_last", bus.m_axis_tdata, 64'hAA);
    check("fullpop_last_vld", 64'(bus.m_axis_tvalid), 64'h1);
    tick();
    check("fullpop_empty", 64'(bus.m_axis_tvalid), 64'h0);

    // Push into empty array while the output register is popped.
    drive(1'b1, 64'h1111, 1'b0);
    tick();
    drive(1'b1, 64'h2222, 1'b1);
    tick();
    check("bypass_occ", 64'(occupancy), 64'h1);
    check("bypass_data", bus.m_axis_tdata, 64'h2222);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check("bypass_empty", 64'(occupancy), 64'h0);

    // Random stalls and pushes against a queue model, then drain.
    mdrop = 0;
    for (int i = 0; i < 320; i++) begin
      check("rnd_vld", 64'(bus.m_axis_tvalid), 64'(q.size() != 0));
      if (q.size() != 0) check("rnd_data", bus.m_axis_tdata, q[0]);
      check("rnd_occ", 64'(occupancy), 64'(q.size()));
      check("rnd_drop", 64'(drop_count), 64'(mdrop));
      if (i < 300) begin
        push_r = ($urandom_range(0, 3) != 0);
        rdy_r  = 1'($urandom_range(0, 1));
      end else begin
        push_r = 1'b0;
        rdy_r  = 1'b1;
      end
      d_r   = {$urandom, $urandom};
      pop_m = (q.size() != 0) && rdy_r;
      acc_m = push_r && ((q.size() < 16) || pop_m);
      drive(push_r, d_r, rdy_r);
      tick();
      if (pop_m) void'(q.pop_front());
      if (acc_m) q.push_back(d_r);
      if (push_r && !acc_m && mdrop < 15) mdrop++;
    end
    check("rnd_final_occ", 64'(occupancy), 64'h0);

    // Saturation and clear-with-drop.
    drive(1'b0, 64'h0, 1'b0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("sat_pre_drop", 64'(drop_count), 64'h0);
    for (int i = 0; i < 36; i++) begin
      drive(1'b1, 64'h300 + 64'(i), 1'b0);
      tick();
    end
    check("sat_drop", 64'(drop_count), 64'd15);
    check("sat_ovf", 64'(overflow), 64'h1);
    check("sat_occ", 64'(occupancy), 64'd16);
    clear_stats = 1'b1;
    tick();
    check("clrdrop_drop", 64'(drop_count), 64'd1);
    check("clrdrop_ovf", 64'(overflow), 64'h1);
    drive(1'b0, 64'h0, 1'b0);
    tick();
    clear_stats = 1'b0;
    check("clr2_drop", 64'(drop_count), 64'h0);
    check("clr2_ovf", 64'(overflow), 64'h0);
    check("clr2_occ", 64'(occupancy), 64'd16);
    check("clr2_data", bus.m_axis_tdata, 64'h300);

    // Make a drop, drain to 7, then reset mid-operation.
    drive(1'b1, 64'h999, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    bus.m_axis_tready = 1'b0;
    check("pre_rst_occ", 64'(occupancy), 64'd7);
    check("pre_rst_vld", 64'(bus.m_axis_tvalid), 64'h1);
    check("pre_rst_drop", 64'(drop_count), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", 64'(bus.m_axis_tvalid), 64'h0);
    check("async_rst_occ", 64'(occupancy), 64'h0);
    check("async_rst_drop", 64'(drop_count), 64'h0);
    check("async_rst_data", bus.m_axis_tdata, 64'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 64'hBAD, 1'b0);
    tick();
    check("rerst_ignore", 64'(occupancy), 64'h0);
    drive(1'b1, 64'h5555, 1'b0);
    tick();
    check("rerst_vld", 64'(bus.m_axis_tvalid), 64'h1);
    check("rerst_data", bus.m_axis_tdata, 64'h5555);
    check("rerst_occ", 64'(occupancy), 64'h1);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check("rerst_empty", 64'(bus.m_axis_tvalid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_msg_collector.md
CORE_MSG_COLLECTOR -- requirements
Module: core_msg_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 64: core message width in bits.
REQ-002 Parameter DEPTH, default 16: message capacity; power of two, at least 2; the output register counts toward capacity.
REQ-003 Parameter DROP_CNT_WIDTH, default 16: drop counter width in bits.
REQ-004 Port clk, input, 1: sole clock; all logic rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port core_msg_data, input, DATA_WIDTH: message payload from the core wrapper.
REQ-007 Port core_msg_valid, input, 1: one-cycle message strobe; there is no ready, so the source cannot be stalled.
REQ-008 Port m_axis_tdata, output, DATA_WIDTH: buffered message out.
REQ-009 Port m_axis_tvalid, output, 1: m_axis_tdata holds a message.
REQ-010 Port m_axis_tready, input, 1: downstream accepts the message.
REQ-011 Port occupancy, output, clog2(DEPTH)+1: messages held, including the output register.
REQ-012 Port drop_count, output, DROP_CNT_WIDTH: saturating count of discarded messages.
REQ-013 Port overflow, output, 1: sticky flag set by any discard.
REQ-014 Port clear_stats, input, 1: synchronous one-cycle clear of drop_count and overflow.

Function
REQ-015 A push is core_msg_valid=1 in a cycle; a pop is m_axis_tvalid=1 and m_axis_tready=1 in the same cycle.
REQ-016 A push is accepted iff occupancy<DEPTH, or occupancy==DEPTH with a pop in the same cycle.
REQ-017 A push that is not accepted is discarded; stored contents and occupancy are unchanged.
REQ-018 Messages leave strictly in acceptance order, with no loss, duplication or reordering of accepted messages.
REQ-019 Storage: a RAM/array of DEPTH-1 entries plus one output register; read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH-1.
REQ-020 The output stage is first-word fall-through: a message accepted in cycle N into an empty block is visible with m_axis_tvalid=1 after the clock edge ending cycle N (latency 1).
REQ-021 After a pop, the next stored message is presented in the following cycle, with no bubble, so back-to-back pops sustain one message per cycle.
REQ-022 A message accepted while the array is empty and the output register is being popped goes directly into the output register.
REQ-023 occupancy updates registered each cycle: +1 on accept without pop, -1 on pop without accept, unchanged when both or neither occur.
REQ-024 m_axis_tdata and m_axis_tvalid are stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 m_axis_tvalid never depends combinationally on m_axis_tready.
REQ-026 On each discard, drop_count increments by 1 and saturates at all-ones.
REQ-027 On each discard, overflow sets to 1.
REQ-028 When clear_stats=1 in a cycle with no discard, drop_count becomes 0 and overflow becomes 0.
REQ-029 When clear_stats=1 in the same cycle as a discard, drop_count becomes 1 and overflow becomes 1.
REQ-030 clear_stats has no effect on stored messages or occupancy.

Reset
REQ-031 Asserting rst_n=0 immediately and asynchronously clears the pointers, occupancy, m_axis_tvalid, drop_count and overflow to 0, whatever transfer is in progress.
REQ-032 While reset is asserted, m_axis_tdata is 0 and array contents need not be cleared.
REQ-033 Deassertion is synchronized internally; core_msg_valid is ignored in the first cycle after deassertion.
REQ-034 A message arriving in the same cycle that reset asserts is lost and is not counted as a drop.

Verification
REQ-035 Single message: push 0x0123_4567_89AB_CDEF with m_axis_tready=1 -> tvalid=1 with that data exactly one cycle later; occupancy goes 1 then 0.
REQ-036 Fill and drain: 20 consecutive pushes of values 1..20 with m_axis_tready=0, DEPTH=16 -> occupancy=16, drop_count=4, overflow=1; then ready=1 -> outputs 1..16 on 16 consecutive cycles.
REQ-037 Full plus simultaneous pop: at occupancy=16, push 0xAA in the same cycle as a pop -> accepted, occupancy stays 16, drop_count unchanged, 0xAA emerges last.
REQ-038 Stall stability: random m_axis_tready over 1000 random pushes -> the output sequence equals the accepted sequence, and data is held steady while stalled.
REQ-039 Statistics: with DROP_CNT_WIDTH=4, force 20 drops -> drop_count=15; clear_stats together with a drop -> drop_count=1, overflow=1.
REQ-040 Reset mid-operation: rst_n low at occupancy=7 with tvalid=1 -> tvalid, occupancy and drop_count go to 0 before the next edge; after release, the first push emerges correctly.
